seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning log2 of data width; data width W = 2**N.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin a shift; it is sampled only in IDLE.
REQ-005 The block SHALL have port a, input, W, the operand; it is captured on the accepted start.
REQ-006 The block SHALL have port amt, input, N, the shift amount 0..W-1; it is captured on the accepted start.
REQ-007 The block SHALL have port dir, input, 1, direction: 0 = right, 1 = left; it is captured on the accepted start.
REQ-008 The block SHALL have port mode, input, 2, the shift mode: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical); it is captured on the accepted start.
REQ-009 The block SHALL have port b, output, W, the registered result; it holds its value until the next done.
REQ-010 The block SHALL have port busy, output, 1, which is high whenever the state is not IDLE.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse that marks b valid with a new result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE, when start=1 at a clock edge, the block SHALL capture a, amt, dir and mode into a working register, a counter, and mode registers.
REQ-014 On that capture edge, the next state SHALL be SHIFT if amt != 0, else DONE.
REQ-015 Each edge in SHIFT SHALL apply exactly one 1-bit step to the working register and decrement the counter.
REQ-016 In SHIFT, when the counter equals 1 at an edge, the next state SHALL be DONE.
REQ-017 Step rules SHALL be as follows.
- Logical right inserts 0 at the MSB; logical left inserts 0 at the LSB.
- Arithmetic right replicates the MSB; arithmetic left behaves as logical left.
- Rotate moves the bit shifted out into the vacated end.
REQ-018 On entry to DONE, b SHALL be loaded with the final working value; done=1 for exactly that one cycle; the next state SHALL be IDLE unconditionally.
REQ-019 Latency SHALL be amt+1 clock edges from the start-sampling edge to the edge at which done rises (amt=0 gives done in the cycle right after start).
REQ-020 start while busy=1, including the DONE cycle, SHALL be ignored with no effect on the operation in flight.
REQ-021 Changes on a, amt, dir or mode after capture SHALL NOT affect the operation in flight.
REQ-022 The result SHALL equal the combinational shift of a by amt in the captured mode and direction, for every amt in 0..W-1.
REQ-023 b and done SHALL NOT change in IDLE or SHIFT, except under reset.

Reset
REQ-024 While rst=1 at an edge, the state SHALL go to IDLE, and b, the working register and the counter SHALL be 0; done and busy SHALL be 0.
REQ-025 rst SHALL take priority over start and over any operation in flight; an aborted operation SHALL produce no done.
REQ-026 The first start accepted after rst is released SHALL behave exactly as from power-up.

Structure
REQ-027 Mode encodings (LOGICAL, ARITH, ROTATE) and state encodings SHALL live in a shared header, seq_shift_defs.vh, for reuse by the bench.
REQ-028 One combinational sub-module, shift_step, SHALL implement the single 1-bit step (inputs: value, dir, mode; output: stepped value), parametrised by W.
REQ-029 The FSM, counter and result register SHALL reside in seq_shifter.

Verification (N=4, W=16)
REQ-030 Stimulus: a=16'hF000, amt=6, dir=0, mode=00. Required response: b=16'h03C0 with done at the 7th edge after start.
REQ-031 Stimulus: a=16'hF000, amt=4, dir=0, mode=01. Required response: b=16'hFF00 with done at the 5th edge.
REQ-032 Stimulus: a=16'h1234, amt=4, dir=1, mode=10. Required response: b=16'h2341; then a=16'h1234, amt=15, dir=0, mode=10 gives b=16'h2468.
REQ-033 Stimulus: a=16'hABCD, amt=0. Required response: done on the edge after start, b=16'hABCD, busy high for exactly 1 cycle.
REQ-034 Stimulus: start with amt=10, then start pulsed again and a changed while busy. Required response: one done only, and the result from the first operand.
REQ-035 Stimulus: rst asserted 3 cycles into an amt=12 shift. Required response: b=0, busy=0, no done; then a fresh start of 16'h8001, amt=1, dir=1, mode=00 gives b=16'h0002.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Types shared by the sequential shifter; values match seq_shift_defs.vh.
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ARITH   = 2'b01,
        MODE_ROTATE  = 2'b10,
        MODE_RSVD    = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/seq_shift_defs.vh
// Shared encodings for the sequential shifter: shift modes and FSM states.
`ifndef SEQ_SHIFT_DEFS_VH
`define SEQ_SHIFT_DEFS_VH

`define SEQ_SHIFT_MODE_LOGICAL 2'b00
`define SEQ_SHIFT_MODE_ARITH   2'b01
`define SEQ_SHIFT_MODE_ROTATE  2'b10
`define SEQ_SHIFT_MODE_RSVD    2'b11

`define SEQ_SHIFT_ST_IDLE      2'b00
`define SEQ_SHIFT_ST_SHIFT     2'b01
`define SEQ_SHIFT_ST_DONE      2'b10

`define SEQ_SHIFT_DIR_RIGHT    1'b0
`define SEQ_SHIFT_DIR_LEFT     1'b1

`endif

// File: rtl/shift_step.sv
// One 1-bit shift step: logical, arithmetic or rotate, in either direction.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] value,
    input  logic         dir,
    input  logic [1:0]   mode,
    output logic [W-1:0] stepped
);

    logic fill;

    // Bit entering the vacated end; arithmetic left and reserved fall back to logical.
    always_comb begin
        fill    = 1'b0;
        stepped = value;
        if (dir == DIR_LEFT) begin
            if (mode == MODE_ROTATE) begin
                fill = value[W-1];
            end
            stepped = {value[W-2:0], fill};
        end else begin
            if (mode == MODE_ARITH) begin
                fill = value[W-1];
            end else if (mode == MODE_ROTATE) begin
                fill = value[0];
            end
            stepped = {fill, value[W-1:1]};
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-shift replacement: one bit per clock, result and done pulse registered.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2**N-1:0]   a,
    input  logic [N-1:0]      amt,
    input  logic              dir,
    input  logic [1:0]        mode,
    output logic [2**N-1:0]   b,
    output logic              busy,
    output logic              done
);

    localparam int unsigned W = 2**N;

    state_e         state;
    logic [W-1:0]   work;
    logic [N-1:0]   cnt;
    logic           dir_q;
    logic [1:0]     mode_q;
    logic [W-1:0]   stepped;

    shift_step #(.W(W)) u_step (
        .value   (work),
        .dir     (dir_q),
        .mode    (mode_q),
        .stepped (stepped)
    );

    // Result is loaded on the same edge that enters DONE, so done and b appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            work   <= '0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            mode_q <= 2'b00;
            b      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        work   <= a;
                        cnt    <= amt;
                        dir_q  <= dir;
                        mode_q <= mode;
                        busy   <= 1'b1;
                        if (amt != '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_DONE;
                            b     <= a;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= stepped;
                    cnt  <= cnt - N'(1);
                    if (cnt == N'(1)) begin
                        state <= ST_DONE;
                        b     <= stepped;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed table, corner sequences, random ops vs. arithmetic model.
module tb_seq_shifter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [N-1:0]  amt;
    logic          dir;
    logic [1:0]    mode;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    seq_shifter #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .amt   (amt),
        .dir   (dir),
        .mode  (mode),
        .b     (b),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  amt;
        logic        dir;
        logic [1:0]  mode;
        logic [15:0] exp_b;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word shift computed directly from the mode rules.
    function automatic logic [15:0] ref_shift(input logic [15:0] va, input int sh,
                                              input logic vdir, input logic [1:0] vmode);
        logic [31:0] dbl;
        dbl = {va, va};
        if (vmode == 2'b10) begin
            if (vdir) return dbl[31 - sh -: 16];
            else      return dbl[sh +: 16];
        end
        if (vdir) return 16'(va << sh);
        if (vmode == 2'b01) return 16'($signed(va) >>> sh);
        return 16'(va >> sh);
    endfunction

    // Launch one op and watch W+4 edges; optionally disturb inputs while busy.
    task automatic do_op(input logic [15:0] ta, input logic [3:0] tamt, input logic tdir,
                         input logic [1:0] tmode, input bit scramble,
                         output logic [15:0] rb, output int lat, output int ndone, output int nbusy);
        bit seen;
        a = ta; amt = tamt; dir = tdir; mode = tmode; start = 1'b1;
        lat = -1; ndone = 0; nbusy = 0; rb = 'x; seen = 0;
        for (int e = 1; e <= int'(W) + 4; e++) begin
            @(posedge clk); #1;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (!seen) begin lat = e; rb = b; end
                seen = 1;
            end
            if (scramble && !seen) begin
                start = 1'b1;
                a     = 16'($urandom);
                amt   = 4'($urandom);
                dir   = 1'($urandom);
                mode  = 2'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (seen) chk("b_hold", 32'(b), 32'(rb));
    endtask

    task automatic run_check(input string name, input logic [15:0] ta, input logic [3:0] tamt,
                             input logic tdir, input logic [1:0] tmode, input bit scramble,
                             input logic [15:0] exp_b);
        logic [15:0] rb;
        int lat, nd, nb;
        do_op(ta, tamt, tdir, tmode, scramble, rb, lat, nd, nb);
        chk({name, "_b"},       32'(rb),  32'(exp_b));
        chk({name, "_latency"}, 32'(lat), 32'(int'(tamt) + 1));
        chk({name, "_ndone"},   32'(nd),  32'd1);
        chk({name, "_nbusy"},   32'(nb),  32'(int'(tamt) + 1));
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; amt = '0; dir = 1'b0; mode = 2'b00;

        vecs.push_back('{16'hF000, 4'd6,  1'b0, 2'b00, 16'h03C0});
        vecs.push_back('{16'hF000, 4'd4,  1'b0, 2'b01, 16'hFF00});
        vecs.push_back('{16'h1234, 4'd4,  1'b1, 2'b10, 16'h2341});
        vecs.push_back('{16'h1234, 4'd15, 1'b0, 2'b10, 16'h2468});
        vecs.push_back('{16'hABCD, 4'd0,  1'b0, 2'b00, 16'hABCD});
        vecs.push_back('{16'h8001, 4'd15, 1'b1, 2'b01, 16'h8000});
        vecs.push_back('{16'h8001, 4'd15, 1'b0, 2'b11, 16'h0001});
        vecs.push_back('{16'h7FFF, 4'd3,  1'b0, 2'b01, 16'h0FFF});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_b",    32'(b),    32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].amt, vecs[i].dir,
                      vecs[i].mode, 1'b0, vecs[i].exp_b);
        end

        // Restart and operand changes while busy must not disturb the op in flight.
        run_check("busy_ignore", 16'hC3A5, 4'd10, 1'b1, 2'b00, 1'b1, 16'h9400);

        // Reset three edges into a long shift aborts it without a done.
        begin
            int nd;
            a = 16'hFFFF; amt = 4'd12; dir = 1'b0; mode = 2'b01; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("abort_b",    32'(b),    32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            nd = 0;
            for (int e = 0; e < 16; e++) begin
                @(posedge clk); #1;
                if (done || busy) nd++;
            end
            chk("abort_quiet", 32'(nd), 32'd0);
            run_check("after_reset", 16'h8001, 4'd1, 1'b1, 2'b00, 1'b0, 16'h0002);
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [3:0]  ramt;
            logic        rdir;
            logic [1:0]  rmode;
            ra    = 16'($urandom);
            ramt  = 4'($urandom);
            rdir  = 1'($urandom);
            rmode = 2'($urandom);
            run_check($sformatf("rand%0d", i), ra, ramt, rdir, rmode, 1'($urandom),
                      ref_shift(ra, int'(ramt), rdir, rmode));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
